// File: rtl/decode_pkg.sv
// Shared types for the decode stage: decoded-instruction layout, queue entry,
// opcode constants and the control-transfer predicate used by the issue window.
package decode_pkg;

   typedef logic [31:0] word_t;
   typedef logic [31:0] instr_t;
   typedef logic [2:0]  lane_cnt_t;   // holds 0..4 lanes

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
   } alu_op_e;

   typedef enum logic [1:0] {BR_EQ, BR_NE, BR_LEZ, BR_GTZ} br_cond_e;

   typedef struct packed {
      alu_op_e  alu_op;
      br_cond_e br_cond;
      logic     alu_src_imm;
      logic     regwrite;
      logic     memread;
      logic     memwrite;
      logic     branch;
      logic     jump;
      logic     link;
   } control_t;

   typedef struct packed {
      control_t    ctl;
      logic [4:0]  srca;
      logic [4:0]  srcb;
      logic [4:0]  dest;
      word_t       imm;
      word_t       target;        // branch/jump target computed from pc+4
      logic        exception_ri;  // reserved instruction
   } decoded_instr_t;

   typedef struct packed {
      decoded_instr_t instr;
      word_t          pc;
      logic           if_exc;
   } queue_entry_t;

   localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE  = 6'h05, OP_BLEZ  = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B, OP_ANDI = 6'h0C, OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E, OP_LUI  = 6'h0F, OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08, FN_JALR = 6'h09, FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   // A branch or jump owns the following delay slot.
   function automatic logic is_ctrl_transfer(control_t c);
      return c.branch | c.jump;
   endfunction

endpackage

// File: rtl/decode_queue_decoder.sv
// Single-lane combinational MIPS-subset decoder; unknown encodings raise
// exception_ri with all control and source fields cleared.
module decoder
   import decode_pkg::*;
(
   input  logic [31:0]    i_instr,
   input  logic [31:0]    i_pc_plus4,
   output decoded_instr_t o_dec
);

   logic [5:0] w_op, w_funct;
   logic [4:0] w_rs, w_rt, w_rd;
   word_t      w_simm;
   logic       w_ri;

   assign w_op    = i_instr[31:26];
   assign w_funct = i_instr[5:0];
   assign w_rs    = i_instr[25:21];
   assign w_rt    = i_instr[20:16];
   assign w_rd    = i_instr[15:11];
   assign w_simm  = {{16{i_instr[15]}}, i_instr[15:0]};

   // Field extraction and per-opcode control generation.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      o_dec        = '0;
      w_ri         = 1'b0;
      o_dec.srca   = w_rs;
      o_dec.srcb   = w_rt;
      o_dec.imm    = w_simm;
      o_dec.target = i_pc_plus4 + {w_simm[29:0], 2'b00};
      case (w_op)
         OP_SPECIAL: begin
            o_dec.dest         = w_rd;
            o_dec.imm          = {27'd0, i_instr[10:6]};
            o_dec.ctl.regwrite = 1'b1;
            case (w_funct)
               FN_ADDU: o_dec.ctl.alu_op = ALU_ADD;
               FN_SUBU: o_dec.ctl.alu_op = ALU_SUB;
               FN_AND:  o_dec.ctl.alu_op = ALU_AND;
               FN_OR:   o_dec.ctl.alu_op = ALU_OR;
               FN_XOR:  o_dec.ctl.alu_op = ALU_XOR;
               FN_NOR:  o_dec.ctl.alu_op = ALU_NOR;
               FN_SLT:  o_dec.ctl.alu_op = ALU_SLT;
               FN_SLTU: o_dec.ctl.alu_op = ALU_SLTU;
               FN_SLL:  o_dec.ctl.alu_op = ALU_SLL;
               FN_SRL:  o_dec.ctl.alu_op = ALU_SRL;
               FN_SRA:  o_dec.ctl.alu_op = ALU_SRA;
               FN_JR: begin
                  o_dec.ctl.jump     = 1'b1;
                  o_dec.ctl.regwrite = 1'b0;
                  o_dec.dest         = 5'd0;
                  o_dec.srcb         = 5'd0;
               end
               FN_JALR: begin
                  o_dec.ctl.jump = 1'b1;
                  o_dec.ctl.link = 1'b1;
                  o_dec.srcb     = 5'd0;
               end
               default: w_ri = 1'b1;
            endcase
         end
         OP_J, OP_JAL: begin
            o_dec.ctl.jump     = 1'b1;
            o_dec.ctl.link     = (w_op == OP_JAL);
            o_dec.ctl.regwrite = (w_op == OP_JAL);
            o_dec.dest         = (w_op == OP_JAL) ? 5'd31 : 5'd0;
            o_dec.srca         = 5'd0;
            o_dec.srcb         = 5'd0;
            o_dec.target       = {i_pc_plus4[31:28], i_instr[25:0], 2'b00};
         end
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
            o_dec.ctl.branch  = 1'b1;
            o_dec.ctl.alu_op  = ALU_SUB;
            o_dec.ctl.br_cond = br_cond_e'(w_op[1:0]);
            if (w_op[1]) o_dec.srcb = 5'd0;
         end
         OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
            o_dec.ctl.regwrite    = 1'b1;
            o_dec.ctl.alu_src_imm = 1'b1;
            o_dec.ctl.memread     = (w_op == OP_LW);
            o_dec.dest            = w_rt;
            o_dec.srcb            = 5'd0;
            case (w_op)
               OP_SLTI:  o_dec.ctl.alu_op = ALU_SLT;
               OP_SLTIU: o_dec.ctl.alu_op = ALU_SLTU;
               OP_ANDI:  o_dec.ctl.alu_op = ALU_AND;
               OP_ORI:   o_dec.ctl.alu_op = ALU_OR;
               OP_XORI:  o_dec.ctl.alu_op = ALU_XOR;
               OP_LUI:   o_dec.ctl.alu_op = ALU_LUI;
               default:  o_dec.ctl.alu_op = ALU_ADD;
            endcase
            if (w_op inside {OP_ANDI, OP_ORI, OP_XORI}) o_dec.imm = {16'd0, i_instr[15:0]};
            if (w_op == OP_LUI) begin
               o_dec.imm  = {i_instr[15:0], 16'd0};
               o_dec.srca = 5'd0;
            end
         end
         OP_SW: begin
            o_dec.ctl.memwrite    = 1'b1;
            o_dec.ctl.alu_src_imm = 1'b1;
         end
         default: w_ri = 1'b1;
      endcase
      if (w_ri) begin
         o_dec              = '0;
         o_dec.exception_ri = 1'b1;
      end
   end

endmodule

// File: rtl/decode_queue.sv
// Multi-lane decode stage with a circular decoded-instruction buffer. Lanes are
// decoded on enqueue; the oldest entries are offered to issue, never splitting
// a branch/jump from its delay slot.
module decode_queue
   import decode_pkg::*;
#(
   parameter int FETCH_WIDTH = 2,
   parameter int ISSUE_WIDTH = 2,
   parameter int DEPTH       = 8
) (
   input  logic                               clk,
   input  logic                               resetn,
   input  logic                               flush,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [FETCH_WIDTH-1:0]             in_mask,
   input  logic [FETCH_WIDTH-1:0][31:0]       in_instr,
   input  logic [FETCH_WIDTH-1:0][31:0]       in_pc,
   input  logic [FETCH_WIDTH-1:0]             in_if_exc,
   output logic [ISSUE_WIDTH-1:0]             out_valid,
   output decoded_instr_t [ISSUE_WIDTH-1:0]   out_instr,
   output logic [ISSUE_WIDTH-1:0][31:0]       out_pc,
   output logic [ISSUE_WIDTH-1:0]             out_if_exc,
   input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   out_accept,
   output logic [$clog2(DEPTH):0]             occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   queue_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_head, r_tail;
   logic [OCC_W-1:0] r_occ;

   decoded_instr_t   w_dec [FETCH_WIDTH];
   queue_entry_t     w_entry [FETCH_WIDTH];
   queue_entry_t     w_head_entry [ISSUE_WIDTH];
   logic [ISSUE_WIDTH:0] w_offer;   // top bit is a constant-0 sentinel
   logic             w_enq_fire;
   lane_cnt_t        w_enq_cnt, w_offer_cnt;
   logic             w_split;

   assign in_ready   = (OCC_W'(DEPTH) - r_occ) >= OCC_W'(FETCH_WIDTH);
   assign w_enq_fire = in_valid && in_ready && !flush;
   assign occupancy  = r_occ;

   for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_dec
      decoder u_decoder (
         .i_instr    (in_instr[g]),
         .i_pc_plus4 (in_pc[g] + 32'd4),
         .o_dec      (w_dec[g])
      );
      assign w_entry[g] = '{instr: w_dec[g], pc: in_pc[g], if_exc: in_if_exc[g]};
   end

   // Count lanes written this cycle.
   always_comb begin
      w_enq_cnt = '0;
      for (int i = 0; i < FETCH_WIDTH; i++)
         if (w_enq_fire && in_mask[i]) w_enq_cnt = w_enq_cnt + lane_cnt_t'(1);
   end

   // Build the issue window: oldest entries first, then withhold any branch
   // whose delay slot is not offered alongside it (top lane down).
   always_comb begin
      w_offer     = '0;
      w_offer_cnt = '0;
      w_split     = 1'b0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         w_head_entry[k] = r_mem[r_head + PTR_W'(k)];
         w_offer[k]      = OCC_W'(k) < r_occ;
      end
      for (int k = ISSUE_WIDTH - 1; k >= 0; k--)
         if (w_offer[k] && is_ctrl_transfer(w_head_entry[k].instr.ctl) && !w_offer[k+1])
            w_offer[k] = 1'b0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         if (w_offer[k]) w_offer_cnt = w_offer_cnt + lane_cnt_t'(1);
         if (lane_cnt_t'(k + 1) == lane_cnt_t'(out_accept) && is_ctrl_transfer(w_head_entry[k].instr.ctl))
            w_split = 1'b1;
      end
   end

   for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_out
      assign out_valid[g]  = w_offer[g];
      assign out_instr[g]  = w_head_entry[g].instr;
      assign out_pc[g]     = w_head_entry[g].pc;
      assign out_if_exc[g] = w_head_entry[g].if_exc;
   end

   // Entry storage write port.
   // NOTE: the entry array has no reset; validity is tracked solely by head/occupancy.
   always_ff @(posedge clk) begin
      if (w_enq_fire)
         for (int i = 0; i < FETCH_WIDTH; i++)
            if (in_mask[i]) r_mem[r_tail + PTR_W'(i)] <= w_entry[i];
   end

   // Head/tail pointers and occupancy; flush overrides enqueue and dequeue.
   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
      end else if (flush) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
      end else begin
         r_head <= r_head + PTR_W'(out_accept);
         r_tail <= r_tail + PTR_W'(w_enq_cnt);
         r_occ  <= r_occ + OCC_W'(w_enq_cnt) - OCC_W'(out_accept);
      end
   end

   a_accept_le_offer: assert property (@(posedge clk) disable iff (!resetn || flush)
      lane_cnt_t'(out_accept) <= w_offer_cnt)
      else $error("out_accept exceeds offered lanes");

   a_no_delay_slot_split: assert property (@(posedge clk) disable iff (!resetn || flush)
      !w_split)
      else $error("out_accept separates a branch from its delay slot");

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (FETCH_WIDTH=2, ISSUE_WIDTH=2, DEPTH=8).
module tb_decode_queue;
   import decode_pkg::*;

   localparam logic [31:0] I_ADDU  = 32'h0022_1821;  // addu $3,$1,$2
   localparam logic [31:0] I_LW    = 32'h8C24_0008;  // lw   $4,8($1)
   localparam logic [31:0] I_BEQ   = 32'h1022_0004;  // beq  $1,$2,+4
   localparam logic [31:0] I_NOP   = 32'h0000_0000;
   localparam logic [31:0] I_RSVD  = 32'hFC00_0000;
   localparam logic [31:0] I_RSVD2 = 32'hFC22_0000;

   logic                  clk = 1'b0;
   logic                  resetn = 1'b0;
   logic                  flush = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [1:0]            in_mask = '0;
   logic [1:0][31:0]      in_instr = '0;
   logic [1:0][31:0]      in_pc = '0;
   logic [1:0]            in_if_exc = '0;
   logic [1:0]            out_valid;
   decoded_instr_t [1:0]  out_instr;
   logic [1:0][31:0]      out_pc;
   logic [1:0]            out_if_exc;
   logic [1:0]            out_accept = '0;
   logic [3:0]            occupancy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   decode_queue #(.FETCH_WIDTH(2), .ISSUE_WIDTH(2), .DEPTH(8)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_mask    (in_mask),
      .in_instr   (in_instr),
      .in_pc      (in_pc),
      .in_if_exc  (in_if_exc),
      .out_valid  (out_valid),
      .out_instr  (out_instr),
      .out_pc     (out_pc),
      .out_if_exc (out_if_exc),
      .out_accept (out_accept),
      .occupancy  (occupancy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of stimulus, clock it, and return 1 time unit after the edge.
   task automatic drive(input logic v, input logic [1:0] m,
                        input logic [31:0] i0, input logic [31:0] p0,
                        input logic [31:0] i1, input logic [31:0] p1,
                        input logic [1:0] exc, input logic [1:0] acc);
      in_valid    = v;
      in_mask     = m;
      in_instr[0] = i0;
      in_pc[0]    = p0;
      in_instr[1] = i1;
      in_pc[1]    = p1;
      in_if_exc   = exc;
      out_accept  = acc;
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      in_mask    = '0;
      in_if_exc  = '0;
      out_accept = '0;
   endtask

   task automatic idle_accept(input logic [1:0] acc);
      drive(1'b0, 2'b00, I_NOP, 32'h0, I_NOP, 32'h0, 2'b00, acc);
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_occupancy", 32'(occupancy), 32'h0);
      check("rst_in_ready",  32'(in_ready),  32'h1);
      @(posedge clk);
      #1 resetn = 1'b1;

      // Stream: addu + lw
      drive(1'b1, 2'b11, I_ADDU, 32'h1000, I_LW, 32'h1004, 2'b00, 2'd0);
      check("stream_valid",    32'(out_valid), 32'h3);
      check("stream_pc0",      out_pc[0], 32'h1000);
      check("stream_pc1",      out_pc[1], 32'h1004);
      check("stream_memread1", 32'(out_instr[1].ctl.memread), 32'h1);
      check("stream_memread0", 32'(out_instr[0].ctl.memread), 32'h0);
      check("stream_dest0",    32'(out_instr[0].dest), 32'h3);
      check("stream_occ",      32'(occupancy), 32'h2);
      idle_accept(2'd2);
      check("stream_drained",  32'(occupancy), 32'h0);
      check("stream_empty",    32'(out_valid), 32'h0);

      // Delay slot: beq in the last lane is held until its slot is alongside
      drive(1'b1, 2'b11, I_ADDU, 32'h2000, I_BEQ, 32'h2004, 2'b00, 2'd0);
      check("ds_held_valid", 32'(out_valid), 32'h1);
      drive(1'b1, 2'b01, I_NOP, 32'h2008, I_NOP, 32'h0, 2'b00, 2'd0);
      check("ds_still_held", 32'(out_valid), 32'h1);
      check("ds_occ3",       32'(occupancy), 32'h3);
      idle_accept(2'd1);
      check("ds_pair_valid", 32'(out_valid), 32'h3);
      check("ds_pair_pc0",   out_pc[0], 32'h2004);
      check("ds_pair_pc1",   out_pc[1], 32'h2008);
      check("ds_branch",     32'(out_instr[0].ctl.branch), 32'h1);
      check("ds_target",     out_instr[0].target, 32'h2018);
      idle_accept(2'd2);
      check("ds_drained",    32'(occupancy), 32'h0);

      // Full and pointer wrap (head/tail start at 5)
      drive(1'b1, 2'b11, I_NOP, 32'h3000, I_NOP, 32'h3004, 2'b00, 2'd0);
      drive(1'b1, 2'b11, I_NOP, 32'h3008, I_NOP, 32'h300C, 2'b00, 2'd0);
      drive(1'b1, 2'b11, I_NOP, 32'h3010, I_NOP, 32'h3014, 2'b00, 2'd0);
      check("full_occ6",   32'(occupancy), 32'h6);
      check("full_ready6", 32'(in_ready),  32'h1);
      drive(1'b1, 2'b01, I_NOP, 32'h3018, I_NOP, 32'h0, 2'b00, 2'd0);
      check("full_occ7",   32'(occupancy), 32'h7);
      check("full_ready7", 32'(in_ready),  32'h0);
      drive(1'b1, 2'b11, I_NOP, 32'h4000, I_NOP, 32'h4004, 2'b00, 2'd1);
      check("full_drop_occ", 32'(occupancy), 32'h6);
      check("full_ready_again", 32'(in_ready), 32'h1);
      drive(1'b1, 2'b11, I_NOP, 32'h301C, I_NOP, 32'h3020, 2'b00, 2'd0);
      check("full_occ8",   32'(occupancy), 32'h8);
      check("full_ready8", 32'(in_ready),  32'h0);
      for (int j = 0; j < 4; j++) begin
         check($sformatf("wrap_valid_%0d", j), 32'(out_valid), 32'h3);
         check($sformatf("wrap_pc0_%0d", j), out_pc[0], 32'h3004 + 32'(8 * j));
         check($sformatf("wrap_pc1_%0d", j), out_pc[1], 32'h3008 + 32'(8 * j));
         idle_accept(2'd2);
      end
      check("wrap_drained", 32'(occupancy), 32'h0);

      // Flush colliding with enqueue and dequeue
      drive(1'b1, 2'b11, I_NOP, 32'h5000, I_NOP, 32'h5004, 2'b00, 2'd0);
      drive(1'b1, 2'b11, I_NOP, 32'h5008, I_NOP, 32'h500C, 2'b00, 2'd0);
      check("flush_pre_occ", 32'(occupancy), 32'h4);
      flush = 1'b1;
      drive(1'b1, 2'b11, I_NOP, 32'h6000, I_NOP, 32'h6004, 2'b00, 2'd2);
      flush = 1'b0;
      check("flush_occ",   32'(occupancy), 32'h0);
      check("flush_valid", 32'(out_valid), 32'h0);
      check("flush_ready", 32'(in_ready),  32'h1);
      idle_accept(2'd0);
      check("flush_no_ghost", 32'(out_valid), 32'h0);
      drive(1'b1, 2'b01, I_NOP, 32'h7000, I_NOP, 32'h0, 2'b00, 2'd0);
      check("flush_after_valid", 32'(out_valid), 32'h1);
      check("flush_after_pc",    out_pc[0], 32'h7000);
      idle_accept(2'd1);

      // Reserved opcode with and without fetch exception
      drive(1'b1, 2'b11, I_RSVD, 32'h8000, I_RSVD2, 32'h8004, 2'b01, 2'd0);
      check("ri_valid",  32'(out_valid), 32'h3);
      check("ri_ri0",    32'(out_instr[0].exception_ri), 32'h1);
      check("ri_exc0",   32'(out_if_exc[0]), 32'h1);
      check("ri_srca0",  32'(out_instr[0].srca), 32'h0);
      check("ri_srcb0",  32'(out_instr[0].srcb), 32'h0);
      check("ri_ri1",    32'(out_instr[1].exception_ri), 32'h1);
      check("ri_exc1",   32'(out_if_exc[1]), 32'h0);
      check("ri_srca1",  32'(out_instr[1].srca), 32'h0);
      check("ri_srcb1",  32'(out_instr[1].srcb), 32'h0);
      idle_accept(2'd2);

      // Asynchronous reset mid-run with occupancy 5
      drive(1'b1, 2'b11, I_NOP, 32'h9000, I_NOP, 32'h9004, 2'b00, 2'd0);
      drive(1'b1, 2'b11, I_NOP, 32'h9008, I_NOP, 32'h900C, 2'b00, 2'd0);
      drive(1'b1, 2'b01, I_NOP, 32'h9010, I_NOP, 32'h0, 2'b00, 2'd0);
      check("mrst_pre_occ", 32'(occupancy), 32'h5);
      #2 resetn = 1'b0;
      #1;
      check("mrst_valid", 32'(out_valid), 32'h0);
      check("mrst_occ",   32'(occupancy), 32'h0);
      check("mrst_ready", 32'(in_ready),  32'h1);
      @(posedge clk);
      #1 resetn = 1'b1;
      idle_accept(2'd0);
      check("mrst_no_reappear", 32'(out_valid), 32'h0);
      check("mrst_occ_after",   32'(occupancy), 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
